// File: rtl/add_pipe_nbits.sv
// Pipelined WIDTH-bit adder/subtractor for the mantissa datapath.
// The operation is split into SEG_WIDTH-bit segments, one segment per stage,
// with the carry between segments registered. Operand bits that are not yet
// summed ride forward in skew registers. Result bits that are already summed
// ride forward in deskew registers, so the last stage presents an aligned
// result. A single advance enable stalls the whole pipeline when the output
// is held.
module add_pipe_nbits #(
   parameter int WIDTH     = 36,
   parameter int SEG_WIDTH = 12
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data_one,
   input  logic [WIDTH-1:0] i_data_two,
   input  logic             i_carry,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_carry
);

   // Number of segments; this is also the latency in cycles.
   localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

   // The pipeline advances whenever the output slot is empty or is being
   // drained this cycle.
   logic en;

   for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
      // LO is the first bit this stage sums, and SW is its segment width.
      // The last segment is narrower when WIDTH is not a multiple of SEG_WIDTH.
      localparam int LO   = gi * SEG_WIDTH;
      localparam int SW   = ((WIDTH - LO) < SEG_WIDTH) ? (WIDTH - LO) : SEG_WIDTH;
      // IN_W counts the operand bits still unsummed on entry to this stage.
      localparam int IN_W = WIDTH - LO;
      // REM counts the operand bits still unsummed after this stage.
      localparam int REM  = IN_W - SW;
      // DONE counts the result bits that are complete after this stage.
      localparam int DONE = LO + SW;

      logic [IN_W-1:0] opa_in;
      logic [IN_W-1:0] opb_in;
      logic            carry_in;
      logic            valid_in;
      logic [SW:0]     seg_sum;
      logic [DONE-1:0] sum_next;

      logic            valid_reg;
      logic            carry_reg;
      logic [DONE-1:0] sum_reg;

      if (gi == 0) begin : g_head
         // Fold the mode in once at the entry. B is inverted for subtract,
         // and the borrow-in becomes a carry-in. Only i_carry and i_sub
         // feed the carry into stage 0.
         assign opa_in   = i_data_one;
         assign opb_in   = i_data_two ^ {WIDTH{i_sub}};
         assign carry_in = i_carry ^ i_sub;
         assign valid_in = i_valid;
         assign sum_next = seg_sum[SW-1:0];
      end else begin : g_body
         // Take the unsummed operands, the carry and the finished low
         // result bits from the previous stage.
         assign opa_in   = g_stage[gi-1].g_skew.opa_reg;
         assign opb_in   = g_stage[gi-1].g_skew.opb_reg;
         assign carry_in = g_stage[gi-1].carry_reg;
         assign valid_in = g_stage[gi-1].valid_reg;
         assign sum_next = {seg_sum[SW-1:0], g_stage[gi-1].sum_reg};
      end

      // Sum this stage's segment with the carry from the previous stage.
      assign seg_sum = {1'b0, opa_in[SW-1:0]}
                     + {1'b0, opb_in[SW-1:0]}
                     + {{SW{1'b0}}, carry_in};

      // Stage register: valid, carry and deskewed result.
      // All of it holds when the pipeline is stalled.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            valid_reg <= 1'b0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
         end else if (en) begin
            valid_reg <= valid_in;
            carry_reg <= seg_sum[SW];
            sum_reg   <= sum_next;
         end
      end

      if (REM > 0) begin : g_skew
         logic [REM-1:0] opa_reg;
         logic [REM-1:0] opb_reg;

         // Skew register: carry the operand bits that are still unsummed
         // forward to the next stage.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               opa_reg <= '0;
               opb_reg <= '0;
            end else if (en) begin
               opa_reg <= opa_in[IN_W-1:SW];
               opb_reg <= opb_in[IN_W-1:SW];
            end
         end
      end
   end

   // The last stage drives the outputs directly.
   assign o_valid = g_stage[NSEG-1].valid_reg;
   assign o_data  = g_stage[NSEG-1].sum_reg;
   assign o_carry = g_stage[NSEG-1].carry_reg;

   // o_ready does not depend on i_valid.
   assign en      = !o_valid || i_ready;
   assign o_ready = en;

endmodule

// File: tb/tb_add_pipe_nbits.sv
// Self-checking bench for add_pipe_nbits.
// One 36/12 instance runs the directed scenarios: carry ripple, subtract,
// backpressure and mid-flight reset.
// A set of instances with other WIDTH/SEG_WIDTH pairs runs random traffic.
// Each instance compares its outputs against a plain-arithmetic model
// through a queue.
`timescale 1ns/1ps
module tb_add_pipe_nbits;

   localparam int NCFG  = 11;
   localparam int NRAND = 910;

   typedef struct {
      longint unsigned d;
      bit              c;
      int              acc;
      bit              lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_done = 0;

   logic rst_g = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: the sum or difference of the operands as plain integers.
   // In add mode the carry is the bit above WIDTH.
   // In subtract mode the carry is set when the difference is not negative,
   // meaning there was no borrow.
   function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                  input bit c, input bit s, input int w);
      exp_t            e;
      longint          r;
      longint unsigned m;
      m = (64'd1 << w) - 64'd1;
      if (s) r = longint'(a) - longint'(b) - longint'(c);
      else   r = longint'(a) + longint'(b) + longint'(c);
      e.d   = longint'(r) & m;
      e.c   = s ? (r >= 0) : (((longint'(r) >> w) & 64'd1) != 0);
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   // Operand generator, biased toward all-ones and zero to exercise long
   // carry and borrow chains.
   function automatic longint unsigned pick(input longint unsigned m);
      case ($urandom_range(0, 5))
         0:       return m;
         1:       return 64'd0;
         default: return {$urandom, $urandom} & m;
      endcase
   endfunction

   function automatic int cfg_w(input int i);
      case (i)
         0, 1, 2:    return 8;
         3, 4, 5:    return 36;
         6, 7, 8:    return 53;
         default:    return 36;
      endcase
   endfunction

   function automatic int cfg_s(input int i);
      case (i)
         0:       return 1;
         1:       return 7;
         2:       return 8;
         3:       return 1;
         4:       return 7;
         5:       return 36;
         6:       return 1;
         7:       return 7;
         8:       return 53;
         9:       return 10;
         default: return 12;
      endcase
   endfunction

   // ---------------- directed instance, WIDTH=36 SEG_WIDTH=12 ----------------
   logic        rst_m = 1'b1;
   logic [35:0] m_a = '0, m_b = '0, m_d;
   logic        m_vld = 1'b0, m_ordy, m_irdy = 1'b1, m_cin = 1'b0, m_sub = 1'b0;
   logic        m_ovld, m_oc;
   exp_t        mq[$];

   add_pipe_nbits #(.WIDTH(36), .SEG_WIDTH(12)) u_dut (
      .i_clk      (clk),
      .i_rst      (rst_m),
      .i_valid    (m_vld),
      .o_ready    (m_ordy),
      .i_data_one (m_a),
      .i_data_two (m_b),
      .i_carry    (m_cin),
      .i_sub      (m_sub),
      .o_valid    (m_ovld),
      .i_ready    (m_irdy),
      .o_data     (m_d),
      .o_carry    (m_oc)
   );

   task automatic m_send(input longint unsigned av, input longint unsigned bv,
                         input bit c, input bit s, input bit lat);
      exp_t e;
      bit   ok;
      ok    = 1'b0;
      m_a   = av[35:0];
      m_b   = bv[35:0];
      m_cin = c;
      m_sub = s;
      m_vld = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (m_ordy) begin
            e     = model(av, bv, c, s, 36);
            e.acc = cyc;
            e.lat = lat;
            mq.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      m_vld = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got o_ready=0 for 50 cycles, required acceptance");
      end
   endtask

   task automatic m_drain(input string name);
      for (int n = 0; n < 100 && mq.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      check(name, mq.size(), 0);
   endtask

   // Directed monitor: pops the queue on each output transfer and checks that
   // a held output stays stable.
   initial begin : m_mon
      exp_t        e;
      bit          hold;
      logic [35:0] hd;
      logic        hc;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_m) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("hold_valid", m_ovld, 1);
               check("hold_data", m_d, hd);
               check("hold_carry", m_oc, hc);
            end
            if (m_ovld && m_irdy) begin
               if (mq.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_output: got data 0x%0h, required no result", m_d);
               end else begin
                  e = mq.pop_front();
                  $display("txn @%0d data=0x%09h carry=%0b (want 0x%09h/%0b)",
                           cyc, m_d, m_oc, e.d, e.c);
                  check("data", m_d, e.d);
                  check("carry", m_oc, e.c);
                  if (e.lat) check("latency", cyc - e.acc, 3);
               end
            end
            hold = m_ovld && !m_irdy;
            hd   = m_d;
            hc   = m_oc;
         end
      end
   end

   // ---------------- random instances over several geometries ----------------
   for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int W  = cfg_w(gi);
      localparam int S  = cfg_s(gi);
      localparam int NS = (W + S - 1) / S;

      logic [W-1:0] a = '0, b = '0, d;
      logic         vld = 1'b0, ordy, irdy = 1'b1, cin = 1'b0, sub = 1'b0, ovld, ocar;
      exp_t         q[$];

      add_pipe_nbits #(.WIDTH(W), .SEG_WIDTH(S)) u_dut (
         .i_clk      (clk),
         .i_rst      (rst_g),
         .i_valid    (vld),
         .o_ready    (ordy),
         .i_data_one (a),
         .i_data_two (b),
         .i_carry    (cin),
         .i_sub      (sub),
         .o_valid    (ovld),
         .i_ready    (irdy),
         .o_data     (d),
         .o_carry    (ocar)
      );

      initial begin : drv
         longint unsigned m, av, bv;
         exp_t            e;
         m = (64'd1 << W) - 64'd1;
         wait (rst_g == 1'b0);
         @(posedge clk);
         #1;
         // First item: both MSBs set with carry-in. It wraps to 1 with
         // carry-out 1, and its latency is checked.
         av  = 64'd1 << (W - 1);
         bv  = av;
         a   = av[W-1:0];
         b   = bv[W-1:0];
         cin = 1'b1;
         sub = 1'b0;
         vld = 1'b1;
         @(negedge clk);
         check($sformatf("w%0d_s%0d first_ready", W, S), ordy, 1);
         if (ordy) begin
            e     = model(av, bv, 1'b1, 1'b0, W);
            e.acc = cyc;
            e.lat = 1'b1;
            q.push_back(e);
         end
         @(posedge clk);
         #1;
         vld = 1'b0;
         for (int n = 0; n < NS + 20 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
         end
         check($sformatf("w%0d_s%0d first_drain", W, S), q.size(), 0);
         for (int n = 0; n < NRAND; n++) begin
            av   = pick(m);
            bv   = pick(m);
            a    = av[W-1:0];
            b    = bv[W-1:0];
            cin  = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            vld  = ($urandom_range(0, 3) != 0);
            irdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (vld && ordy) begin
               e = model(av, bv, cin, sub, W);
               e.acc = cyc;
               q.push_back(e);
            end
            @(posedge clk);
            #1;
         end
         vld  = 1'b0;
         irdy = 1'b1;
         for (int n = 0; n < NS + 200 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
         end
         check($sformatf("w%0d_s%0d drain", W, S), q.size(), 0);
         n_done++;
      end

      initial begin : mon
         exp_t         e;
         bit           hold;
         logic [W-1:0] hd;
         logic         hc;
         hold = 1'b0;
         forever begin
            @(negedge clk);
            if (hold) begin
               check($sformatf("w%0d_s%0d hold_valid", W, S), ovld, 1);
               check($sformatf("w%0d_s%0d hold_data", W, S), d, hd);
               check($sformatf("w%0d_s%0d hold_carry", W, S), ocar, hc);
            end
            if (ovld && irdy) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL w%0d_s%0d unexpected_output: got data 0x%0h, required no result", W, S, d);
               end else begin
                  e = q.pop_front();
                  check($sformatf("w%0d_s%0d data", W, S), d, e.d);
                  check($sformatf("w%0d_s%0d carry", W, S), ocar, e.c);
                  if (e.lat) check($sformatf("w%0d_s%0d latency", W, S), cyc - e.acc, NS);
               end
            end
            hold = ovld && !irdy;
            hd   = d;
            hc   = ocar;
         end
      end
   end

   // ---------------- directed sequence and summary ----------------
   initial begin : main
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_valid", m_ovld, 0);
      check("reset_data", m_d, 0);
      check("reset_carry", m_oc, 0);
      check("reset_ready", m_ordy, 1);
      @(posedge clk);
      #1;
      rst_m = 1'b0;
      rst_g = 1'b0;

      // Carry rippling through all three segments.
      m_send(64'hF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
      m_drain("ripple_drain");

      // Subtract with a borrow out, then without one, then with a borrow-in.
      m_send(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
      m_drain("sub_borrow_drain");
      m_send(64'd7, 64'd5, 1'b0, 1'b1, 1'b1);
      m_drain("sub_noborrow_drain");
      m_send(64'd7, 64'd5, 1'b1, 1'b1, 1'b1);
      m_drain("sub_borrowin_drain");

      // Backpressure: five back-to-back items, with i_ready held low for 4
      // cycles once the first result shows.
      fork
         begin
            for (int k = 1; k <= 5; k++)
               m_send(longint'(k), longint'(k) * 64'h1000, 1'b0, 1'b0, 1'b0);
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 30 && !seen; n++) begin
               @(posedge clk);
               #1;
               seen = m_ovld;
            end
            m_irdy = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("bp_ready_low", m_ordy, 0);
               check("bp_data_held", m_d, 64'h1001);
               @(posedge clk);
               #1;
            end
            m_irdy = 1'b1;
         end
      join
      m_drain("bp_drain");

      // Mid-flight reset discards both in-flight items.
      m_send(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
      m_send(64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
      rst_m = 1'b1;
      mq.delete();
      @(posedge clk);
      #1;
      rst_m = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("flush_valid", m_ovld, 0);
         @(posedge clk);
         #1;
      end
      m_send(64'd1, 64'd2, 1'b0, 1'b0, 1'b1);
      m_drain("post_reset_drain");

      for (int n = 0; n < 60000 && n_done < NCFG; n++) @(posedge clk);
      if (n_done < NCFG) begin
         n_cmp++;
         n_bad++;
         $display("FAIL random_timeout: got %0d configs done, required %0d", n_done, NCFG);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
